regfile_init_mp: RTL and testbench



---
 rtl/rf_pkg.sv | 16 +
 rtl/regfile_init_mp_if.sv | 29 ++
 rtl/rf_init_seq.sv | 77 +++++++
 rtl/regfile_init_mp.sv | 73 +++++++
 tb/tb_regfile_init_mp.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the regfile_init_mp register bank: default sizes,
// init-value encodings and the init sequencer state type.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_init_mp_if.sv
// Port bundle of the register bank: decode-side read addresses, writeback
// write port, read data and init status.
interface regfile_init_mp_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              we;
  logic [ADDR_W-1:0] write_add;
  logic [XLEN-1:0]   write_data;
  logic [ADDR_W-1:0] R1_add;
  logic [ADDR_W-1:0] R2_add;
  logic [XLEN-1:0]   reg1;
  logic [XLEN-1:0]   reg2;
  logic              rf_ready;
  logic              wr_drop;
  logic [ADDR_W-1:0] init_cnt;

  modport master (
    output we, write_add, write_data, R1_add, R2_add,
    input  reg1, reg2, rf_ready, wr_drop, init_cnt
  );

  modport slave (
    input  we, write_add, write_data, R1_add, R2_add,
    output reg1, reg2, rf_ready, wr_drop, init_cnt
  );
endinterface

// File: rtl/rf_init_seq.sv
// Init sequencer: walks the array after reset writing init values, then
// hands the array write port to the external writeback port.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_INIT  | writing init value to entry init_cnt each cycle; ext writes dropped
//   ST_READY | array valid; external writes pass through (terminal until reset)
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int INIT_MODE = INIT_INDEX,
  parameter int ZERO_REG0 = 1,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [XLEN-1:0]   write_data,
  output logic              arr_we,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [XLEN-1:0]   arr_data,
  output logic              rf_ready,
  output logic              wr_drop,
  output logic [ADDR_W-1:0] init_cnt
);

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              drop_nxt;

  // State, pointer and status flags; rf_ready follows the next state so it is
  // high from the first READY cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      rf_ready <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= cnt_nxt;
      rf_ready <= (state_nxt == ST_READY);
      wr_drop  <= drop_nxt;
    end
  end

  // Next-state logic and array write-port mux between init engine and writeback.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = init_cnt;
    drop_nxt  = wr_drop;
    arr_we    = 1'b0;
    arr_addr  = write_add;
    arr_data  = write_data;
    case (state)
      ST_INIT: begin
        arr_we   = 1'b1;
        arr_addr = init_cnt;
        arr_data = (INIT_MODE == INIT_INDEX) ? XLEN'(init_cnt) : '0;
        cnt_nxt  = init_cnt + 1'b1;
        if (we) drop_nxt = 1'b1;
        if (init_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end
      end
      ST_READY: begin
        arr_we = we && !((ZERO_REG0 != 0) && (write_add == '0));
      end
      default: state_nxt = ST_INIT;
    endcase
  end

endmodule

// File: rtl/regfile_init_mp.sv
// Register bank: 1 write port, 2 combinational read ports, optional
// hardwired-zero entry 0, sequential init after reset (rf_init_seq).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// to a matching read port once the bank is ready.
module regfile_init_mp
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int INIT_MODE = INIT_INDEX,
  parameter int ZERO_REG0 = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_init_mp_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [XLEN-1:0]   mem [DEPTH];
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [XLEN-1:0]   arr_data;
  logic              rf_ready;
  logic              wr_drop;
  logic [ADDR_W-1:0] init_cnt;
  logic [XLEN-1:0]   rd1, rd2;

  rf_init_seq #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .INIT_MODE (INIT_MODE),
    .ZERO_REG0 (ZERO_REG0),
    .ADDR_W    (ADDR_W)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .we         (bus.we),
    .write_add  (bus.write_add),
    .write_data (bus.write_data),
    .arr_we     (arr_we),
    .arr_addr   (arr_addr),
    .arr_data   (arr_data),
    .rf_ready   (rf_ready),
    .wr_drop    (wr_drop),
    .init_cnt   (init_cnt)
  );

  // Storage array; contents are deliberately not reset, the sequencer fills it.
  always_ff @(posedge clk) begin
    if (arr_we) mem[arr_addr] <= arr_data;
  end

  // Combinational read ports with hardwired zero and optional forwarding.
  always_comb begin
    rd1 = ((ZERO_REG0 != 0) && (bus.R1_add == '0)) ? '0 : mem[bus.R1_add];
    rd2 = ((ZERO_REG0 != 0) && (bus.R2_add == '0)) ? '0 : mem[bus.R2_add];
`ifdef REGFILE_BYPASS_EN
    if (rf_ready && bus.we && (bus.write_add == bus.R1_add) &&
        !((ZERO_REG0 != 0) && (bus.R1_add == '0)))
      rd1 = bus.write_data;
    if (rf_ready && bus.we && (bus.write_add == bus.R2_add) &&
        !((ZERO_REG0 != 0) && (bus.R2_add == '0)))
      rd2 = bus.write_data;
`endif
  end

  assign bus.reg1     = rd1;
  assign bus.reg2     = rd2;
  assign bus.rf_ready = rf_ready;
  assign bus.wr_drop  = wr_drop;
  assign bus.init_cnt = init_cnt;

endmodule

// File: tb/tb_regfile_init_mp.sv
// Directed bench for regfile_init_mp: default instance (index init, 32 entries)
// plus a 16-entry zero-init instance sharing clock and reset.
module tb_regfile_init_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   rise, rise2;

  regfile_init_mp_if #(.XLEN(32), .DEPTH(32)) bus  ();
  regfile_init_mp_if #(.XLEN(32), .DEPTH(16)) bus2 ();

  regfile_init_mp #(.XLEN(32), .DEPTH(32), .INIT_MODE(1), .ZERO_REG0(1)) u_dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  regfile_init_mp #(.XLEN(32), .DEPTH(16), .INIT_MODE(0), .ZERO_REG0(1)) u_dut2 (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.we = 1'b0; bus.write_add = '0; bus.write_data = '0;
    bus.R1_add = '0; bus.R2_add = '0;
    bus2.we = 1'b0; bus2.write_add = '0; bus2.write_data = '0;
    bus2.R1_add = '0; bus2.R2_add = '0;
    #1;
    check("rst_ready", 32'(bus.rf_ready), 32'd0);
    check("rst_drop", 32'(bus.wr_drop), 32'd0);
    check("rst_cnt", 32'(bus.init_cnt), 32'd0);
    tick;
    tick;
    check("rst_ready2", 32'(bus2.rf_ready), 32'd0);

    // Release reset and run through INIT, dropping one write on cycle 3.
    reset_n = 1'b1;
    rise = 0; rise2 = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3) begin
        bus.we = 1'b1; bus.write_add = 5'd3; bus.write_data = 32'hBAD0BAD0;
      end else begin
        bus.we = 1'b0;
      end
      tick;
      if (i == 2) check("drop_before", 32'(bus.wr_drop), 32'd0);
      if (i == 3) check("drop_set", 32'(bus.wr_drop), 32'd1);
      if (i == 5) check("cnt_mid", 32'(bus.init_cnt), 32'd5);
      if (rise == 0 && bus.rf_ready) rise = i;
      if (rise2 == 0 && bus2.rf_ready) rise2 = i;
    end
    bus.we = 1'b0;
    check("ready_edge", 32'(rise), 32'd32);
    check("ready_edge16", 32'(rise2), 32'd16);
    check("drop_sticky", 32'(bus.wr_drop), 32'd1);
    check("drop_dut2", 32'(bus2.wr_drop), 32'd0);
    check("cnt_wrap", 32'(bus.init_cnt), 32'd0);

    // Index-mode init contents.
    bus.R1_add = 5'd5; bus.R2_add = 5'd31; #1;
    check("rd_5", bus.reg1, 32'd5);
    check("rd_31", bus.reg2, 32'd31);
    bus.R1_add = 5'd0; bus.R2_add = 5'd3; #1;
    check("rd_0", bus.reg1, 32'd0);
    check("rd_3_not_dropped", bus.reg2, 32'd3);
    bus.R1_add = 5'd17; bus.R2_add = 5'd17; #1;
    check("same_addr_r1", bus.reg1, 32'd17);
    check("same_addr_r2", bus.reg2, 32'd17);

    // Zero-mode instance: every entry reads 0.
    for (int a = 0; a < 16; a++) begin
      bus2.R1_add = 4'(a); #1;
      check($sformatf("zero_init_%0d", a), bus2.reg1, 32'd0);
    end

    // Write 7, read in the same cycle and the next.
    @(negedge clk);
    bus.we = 1'b1; bus.write_add = 5'd7; bus.write_data = 32'hDEADBEEF;
    bus.R1_add = 5'd7; #1;
    check("wr7_same", bus.reg1, BYP ? 32'hDEADBEEF : 32'd7);
    tick;
    bus.we = 1'b0; #1;
    check("wr7_next", bus.reg1, 32'hDEADBEEF);

    // Both ports on the written address in the write cycle.
    @(negedge clk);
    bus.we = 1'b1; bus.write_add = 5'd9; bus.write_data = 32'hA5A5A5A5;
    bus.R1_add = 5'd9; bus.R2_add = 5'd9; #1;
    check("byp_r1", bus.reg1, BYP ? 32'hA5A5A5A5 : 32'd9);
    check("byp_r2", bus.reg2, BYP ? 32'hA5A5A5A5 : 32'd9);
    tick;
    bus.we = 1'b0; #1;
    check("wr9_r1", bus.reg1, 32'hA5A5A5A5);
    check("wr9_r2", bus.reg2, 32'hA5A5A5A5);

    // Write to entry 0 is ignored, including by forwarding.
    @(negedge clk);
    bus.we = 1'b1; bus.write_add = 5'd0; bus.write_data = 32'h1234;
    bus.R2_add = 5'd0; #1;
    check("wr0_same", bus.reg2, 32'd0);
    tick;
    bus.we = 1'b0; #1;
    check("wr0_next", bus.reg2, 32'd0);

    // Reset in READY clears status immediately.
    @(negedge clk);
    reset_n = 1'b0; #1;
    check("rst_rdy_ready", 32'(bus.rf_ready), 32'd0);
    check("rst_rdy_drop", 32'(bus.wr_drop), 32'd0);
    check("rst_rdy_cnt", 32'(bus.init_cnt), 32'd0);
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    check("cnt_10", 32'(bus.init_cnt), 32'd10);
    check("ready_low_mid", 32'(bus.rf_ready), 32'd0);

    // Reset mid-INIT and count to ready again.
    reset_n = 1'b0; #1;
    check("rst_mid_cnt", 32'(bus.init_cnt), 32'd0);
    tick;
    reset_n = 1'b1;
    rise = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (i == 1) check("restart_cnt", 32'(bus.init_cnt), 32'd1);
      if (rise == 0 && bus.rf_ready) rise = i;
    end
    check("ready_edge_rerun", 32'(rise), 32'd32);
    bus.R1_add = 5'd7; bus.R2_add = 5'd9; #1;
    check("reinit_7", bus.reg1, 32'd7);
    check("reinit_9", bus.reg2, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
